// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//
// Purpose:
//   Brings a raw, asynchronous and possibly bouncing level into the clk
//   domain through a two-flop synchronizer. A small FSM then debounces it.
//   The clean level only changes after DEBOUNCE_CYCLES consecutive
//   synchronized samples disagree with it. Each change of the clean level
//   produces a one-cycle rise or fall pulse. All outputs are registered.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to flip the
//                    clean level (must be >= 2)
//
// Ports:
//   clk      in   sole clock, all state updates on posedge
//   rst      in   synchronous active-low reset
//   a_async  in   raw asynchronous input level
//   a_clean  out  debounced level
//   rise     out  one-cycle pulse when a_clean goes 0 -> 1
//   fall     out  one-cycle pulse when a_clean goes 1 -> 0
//   busy     out  high while a candidate transition is being qualified
// ---------------------------------------------------------------------------
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_async,
  output logic a_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  // A single disagreeing sample would be accepted immediately with fewer
  // than two cycles, which defeats the purpose of the block.
  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    VERIFY_HI = 2'b01,
    STABLE_HI = 2'b10,
    VERIFY_LO = 2'b11
  } state_t;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_clean_q, a_clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             mismatch;

  always_comb begin
    s1_d      = a_async;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_clean_d = a_clean_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;

    // Compared against the registered clean level, so a sample that agrees
    // again during qualification immediately abandons the candidate.
    mismatch  = (s2_q != a_clean_q);

    case (state_q)
      STABLE_LO: begin
        if (mismatch) begin
          state_d = VERIFY_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      VERIFY_HI: begin
        if (mismatch) begin
          if (cnt_q == CNT_MAX) begin
            state_d   = STABLE_HI;
            a_clean_d = 1'b1;
            rise_d    = 1'b1;
            cnt_d     = CNT_ZERO;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end
      end

      STABLE_HI: begin
        if (mismatch) begin
          state_d = VERIFY_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      VERIFY_LO: begin
        if (mismatch) begin
          if (cnt_q == CNT_MAX) begin
            state_d   = STABLE_LO;
            a_clean_d = 1'b0;
            fall_d    = 1'b1;
            cnt_d     = CNT_ZERO;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end
      end

      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // busy is registered from the next state, so it is high in exactly the
    // cycles in which the FSM sits in a VERIFY state.
    busy_d = (state_d == VERIFY_HI) || (state_d == VERIFY_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= STABLE_LO;
      cnt_q     <= CNT_ZERO;
      a_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_clean_q <= a_clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
    end
  end

  assign a_clean = a_clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
//
// Purpose:
//   Self-checking bench for debounce_sync with DEBOUNCE_CYCLES = 4. A table
//   of per-edge vectors covers reset, a clean rising step, a rejected low
//   glitch and a falling step. Hand-written sequences cover a rejected high
//   glitch, a bouncing input, reset during qualification and reset release
//   with the input already high.
//
//   Expected outputs are packed as {a_clean, rise, fall, busy}.
// ---------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int N_VEC = 24;

  logic clk;
  logic rst;
  logic a_async;
  logic a_clean;
  logic rise;
  logic fall;
  logic busy;

  int num_checks;
  int num_fails;
  int overlap_cnt;

  typedef struct {
    logic       rst_n;
    logic       a;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[N_VEC];

  debounce_sync #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_async (a_async),
    .a_clean (a_clean),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rise and fall must never overlap; sampled away from the active edge.
  always @(negedge clk) begin
    if (rise && fall) overlap_cnt++;
  end

  // Drive inputs, take one active edge, and settle just past it.
  task automatic applyStimulus(input logic rst_v, input logic a_v);
    rst     = rst_v;
    a_async = a_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_checks++;
    if (actual != expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int outVec();
    return int'({a_clean, rise, fall, busy});
  endfunction

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    int rise_at;
    int clean_seen;
    int busy_seen;
    logic bounce_vals[5];

    num_checks  = 0;
    num_fails   = 0;
    overlap_cnt = 0;
    rst         = 1'b0;
    a_async     = 1'b0;

    // Row k: inputs present at edge k, outputs expected just after edge k.
    vecs[0]  = '{1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 4'b0000};
    vecs[3]  = '{1'b1, 1'b1, 4'b0000};
    vecs[4]  = '{1'b1, 1'b1, 4'b0000};
    vecs[5]  = '{1'b1, 1'b1, 4'b0001};
    vecs[6]  = '{1'b1, 1'b1, 4'b0001};
    vecs[7]  = '{1'b1, 1'b1, 4'b0001};
    vecs[8]  = '{1'b1, 1'b1, 4'b1100};
    vecs[9]  = '{1'b1, 1'b1, 4'b1000};
    vecs[10] = '{1'b1, 1'b1, 4'b1000};
    vecs[11] = '{1'b1, 1'b0, 4'b1000};
    vecs[12] = '{1'b1, 1'b0, 4'b1000};
    vecs[13] = '{1'b1, 1'b1, 4'b1001};
    vecs[14] = '{1'b1, 1'b1, 4'b1001};
    vecs[15] = '{1'b1, 1'b1, 4'b1000};
    vecs[16] = '{1'b1, 1'b1, 4'b1000};
    vecs[17] = '{1'b1, 1'b0, 4'b1000};
    vecs[18] = '{1'b1, 1'b0, 4'b1000};
    vecs[19] = '{1'b1, 1'b0, 4'b1001};
    vecs[20] = '{1'b1, 1'b0, 4'b1001};
    vecs[21] = '{1'b1, 1'b0, 4'b1001};
    vecs[22] = '{1'b1, 1'b0, 4'b0010};
    vecs[23] = '{1'b1, 1'b0, 4'b0000};

    $display("[TB] table vectors");
    for (int i = 0; i < N_VEC; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].a);
      checkOutput($sformatf("vec[%0d]", i), outVec(), int'(vecs[i].exp));
    end

    // High glitch of three samples: rejected, busy pulses then clears.
    $display("[TB] high glitch");
    resetDut();
    rise_cnt = 0; fall_cnt = 0; clean_seen = 0; busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, (k < 3) ? 1'b1 : 1'b0);
      if (rise) rise_cnt++;
      if (fall) fall_cnt++;
      if (a_clean) clean_seen++;
      if (busy) busy_seen++;
    end
    checkOutput("glitch_rise_count", rise_cnt, 0);
    checkOutput("glitch_fall_count", fall_cnt, 0);
    checkOutput("glitch_clean_high", clean_seen, 0);
    checkOutput("glitch_busy_cycles", busy_seen, 3);
    checkOutput("glitch_busy_clear", int'(busy), 0);

    // Bounce 1,0,1,0,1 then hold 1: one rise, five edges after the final 1.
    $display("[TB] bounce");
    resetDut();
    bounce_vals[0] = 1'b1; bounce_vals[1] = 1'b0; bounce_vals[2] = 1'b1;
    bounce_vals[3] = 1'b0; bounce_vals[4] = 1'b1;
    rise_cnt = 0; fall_cnt = 0; rise_at = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, (k < 5) ? bounce_vals[k] : 1'b1);
      if (rise) begin
        rise_cnt++;
        rise_at = k;
      end
      if (fall) fall_cnt++;
    end
    checkOutput("bounce_rise_count", rise_cnt, 1);
    checkOutput("bounce_rise_edge", rise_at, 9);
    checkOutput("bounce_fall_count", fall_cnt, 0);
    checkOutput("bounce_clean_final", int'(a_clean), 1);

    // Reset while the counter is at 2, then release with the input still high.
    $display("[TB] reset mid-verify");
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_reset_busy", outVec(), 4'b0001);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_mid_verify_outputs", outVec(), 4'b0000);
    rise_cnt = 0; fall_cnt = 0; rise_at = -1;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b1, 1'b1);
      if (rise) begin
        rise_cnt++;
        rise_at = k;
      end
      if (fall) fall_cnt++;
      if (k == 4) checkOutput("release_no_early_clean", int'(a_clean), 0);
    end
    checkOutput("release_rise_count", rise_cnt, 1);
    checkOutput("release_rise_edge", rise_at, 5);
    checkOutput("release_fall_count", fall_cnt, 0);
    checkOutput("release_clean_held", outVec(), 4'b1000);

    checkOutput("rise_fall_exclusive", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive synchronized samples that must disagree with the clean level before the clean level changes.
REQ-002 Parameter legality: DEBOUNCE_CYCLES SHALL be >= 2; elaboration SHALL fail for smaller values.
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset; synchronous and active-low (asserted when 0, sampled on posedge clk).
REQ-005 Port: a_async  input  1  raw, asynchronous, possibly bouncing level.
REQ-006 Port: a_clean  output  1  registered, debounced level; feeds the downstream edge/pulse detector.
REQ-007 Port: rise  output  1  registered one-cycle pulse, high in the first cycle a_clean is 1 after being 0.
REQ-008 Port: fall  output  1  registered one-cycle pulse, high in the first cycle a_clean is 0 after being 1.
REQ-009 Port: busy  output  1  registered; high while a candidate transition is being qualified (VERIFY_* states).

Function
REQ-010 Synchronizer: a_async SHALL pass through exactly two flops (s1, s2) before any other logic; a_sync = s2.
REQ-011 Mismatch is defined as a_sync != a_clean, evaluated every cycle.
REQ-012 FSM states: STABLE_LO, VERIFY_HI, STABLE_HI, VERIFY_LO; encoding free.
REQ-013 STABLE_LO: on mismatch -> VERIFY_HI, counter = 1; else stay, counter = 0.
REQ-014 VERIFY_HI: mismatch and counter == DEBOUNCE_CYCLES-1 -> STABLE_HI, a_clean <= 1, rise <= 1, counter = 0.
REQ-015 VERIFY_HI: mismatch and counter < DEBOUNCE_CYCLES-1 -> stay, counter increments by 1.
REQ-016 VERIFY_HI: no mismatch -> STABLE_LO, counter = 0, no output change (glitch rejected).
REQ-017 STABLE_HI / VERIFY_LO SHALL mirror REQ-013..016 with polarity inverted and fall in place of rise.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits; it SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.
REQ-019 Latency: a_async stable at new value from before edge e -> a_clean changes at edge e+1+DEBOUNCE_CYCLES (s1 at e, s2 at e+1, N mismatch samples at e+2..e+1+N).
REQ-020 Any mismatch run shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no change on a_clean, rise or fall.
REQ-021 rise and fall SHALL never be high simultaneously and SHALL each be high for exactly one cycle per a_clean transition.
REQ-022 Minimum spacing between consecutive a_clean transitions SHALL be DEBOUNCE_CYCLES cycles.
REQ-023 busy SHALL be 1 exactly in cycles following an edge that left the FSM in VERIFY_HI or VERIFY_LO.
REQ-024 Outputs SHALL be glitch-free registered signals; no combinational path from a_async to any output.

Reset
REQ-025 While rst == 0 at a posedge: s1, s2, a_clean, rise, fall, busy, counter all 0; FSM = STABLE_LO.
REQ-026 Reset asserted mid-qualification SHALL abandon the count; no rise/fall emitted for the pending transition.
REQ-027 a_async high at reset release SHALL be treated as a normal 0->1 transition: rise after the REQ-019 latency measured from the first non-reset edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Clean step: a_async 0->1 before edge 10, held -> a_clean = 1 and rise = 1 for one cycle from edge 15; busy high after edges 12-14.
REQ-029 Glitch: a_async high for 3 cycles then low -> a_clean stays 0, rise/fall never asserted, busy pulses then clears.
REQ-030 Bounce: a_async toggles 1,0,1,0,1 each cycle then holds 1 -> exactly one rise, 4 cycles after the final 0->1 reaches s2.
REQ-031 Falling edge: from a_clean = 1, a_async 1->0 held -> fall = 1 one cycle, a_clean = 0, rise stays 0.
REQ-032 Reset mid-verify: rst = 0 for one edge while counter = 2 -> all outputs 0, FSM STABLE_LO, no pulse; requalification restarts from counter = 0.
REQ-033 Reset release with a_async = 1 -> rise at first-non-reset-edge + 5, then a_clean stays 1.
